// File: rtl/neo_pkg.sv
// Shared types and default configuration for the NEO spike detector slice.
package neo_pkg;

  localparam int unsigned NEO_M_DEF        = 16;
  localparam int unsigned NEO_TW_DEF       = 16;
  localparam int unsigned NEO_REFRACT_DEF  = 8;
  localparam int unsigned NEO_WIN_LOG2_DEF = 4;
  localparam int unsigned NEO_K_SHIFT_DEF  = 3;

  typedef enum logic [1:0] {
    ARMED,
    ABOVE,
    EMIT,
    REFRACT
  } det_state_t;

endpackage

// File: rtl/neo_ema_threshold.sv
// Adaptive threshold: EMA of accepted energy, threshold = EMA << K_SHIFT
// saturated to all-ones, plus a warm-up counter gating detection.
module neo_ema_threshold
  import neo_pkg::*;
#(
  parameter int unsigned M        = NEO_M_DEF,
  parameter int unsigned WIN_LOG2 = NEO_WIN_LOG2_DEF,
  parameter int unsigned K_SHIFT  = NEO_K_SHIFT_DEF
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         accept_i,
  input  logic [M-1:0] energy_i,
  output logic [M-1:0] thr_o,
  output logic         warm_o
);

  localparam int unsigned WC = WIN_LOG2 + 1;
  localparam int unsigned SW = M + K_SHIFT + 1;
  localparam logic [M-1:0] MAXV = '1;

  logic [M-1:0]        avg_q, avg_d;
  logic [M-1:0]        thr_q, thr_d;
  logic [WC-1:0]       wcnt_q, wcnt_d;
  logic signed [M:0]   diff;
  logic signed [M:0]   step;
  logic [M:0]          sum;
  logic [SW-1:0]       shifted;

  // EMA step in signed M+1 bits, then scaled and saturated threshold
  always_comb begin
    diff    = $signed({1'b0, energy_i}) - $signed({1'b0, avg_q});
    step    = diff >>> WIN_LOG2;
    sum     = {1'b0, avg_q} + $unsigned(step);
    avg_d   = sum[M-1:0];
    shifted = SW'(avg_d) << K_SHIFT;
    thr_d   = (shifted > SW'(MAXV)) ? MAXV : shifted[M-1:0];
    wcnt_d  = wcnt_q[WIN_LOG2] ? wcnt_q : wcnt_q + 1'b1;
  end

  // Average, threshold and warm-up count advance only on accepted samples
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      avg_q  <= '0;
      thr_q  <= '0;
      wcnt_q <= '0;
    end else if (accept_i) begin
      avg_q  <= avg_d;
      thr_q  <= thr_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign thr_o  = thr_q;
  assign warm_o = wcnt_q[WIN_LOG2];

endmodule

// File: rtl/neo_spike_detector.sv
// NEO spike detector: thresholds the energy stream, groups each
// supra-threshold run into one (peak, index) event, then a refractory gap.
// Define NEO_DET_ADAPTIVE_EN for the EMA-derived threshold; otherwise
// fixed_thresh is used directly.
module neo_spike_detector #(
  parameter int unsigned M        = neo_pkg::NEO_M_DEF,
  parameter int unsigned TW       = neo_pkg::NEO_TW_DEF,
  parameter int unsigned REFRACT  = neo_pkg::NEO_REFRACT_DEF,
  parameter int unsigned WIN_LOG2 = neo_pkg::NEO_WIN_LOG2_DEF,
  parameter int unsigned K_SHIFT  = neo_pkg::NEO_K_SHIFT_DEF
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          energy_valid,
  input  logic [M-1:0]  energy,
  output logic          energy_ready,
  input  logic [M-1:0]  fixed_thresh,
  output logic          spike_valid,
  input  logic          spike_ready,
  output logic [TW-1:0] spike_time,
  output logic [M-1:0]  spike_peak
);

  // The REFRACT state literal is reached through the package scope because
  // the parameter of the same name shadows it here.
  import neo_pkg::det_state_t;
  import neo_pkg::ARMED;
  import neo_pkg::ABOVE;
  import neo_pkg::EMIT;

  localparam int unsigned CW = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);

  det_state_t    state_q, state_d;
  logic [M-1:0]  peak_q, peak_d;
  logic [TW-1:0] ptime_q, ptime_d;
  logic [TW-1:0] ts_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  thr;
  logic          warm;
  logic          accept;
  logic          unused_cfg;

  assign energy_ready = !reset && (state_q != EMIT);
  assign accept       = energy_valid && energy_ready;

`ifdef NEO_DET_ADAPTIVE_EN
  neo_ema_threshold #(
    .M        (M),
    .WIN_LOG2 (WIN_LOG2),
    .K_SHIFT  (K_SHIFT)
  ) u_ema (
    .clk_i    (Clk),
    .reset_i  (reset),
    .accept_i (accept),
    .energy_i (energy),
    .thr_o    (thr),
    .warm_o   (warm)
  );

  assign unused_cfg = ^fixed_thresh;
`else
  logic [M-1:0] thr_q;

  // Fixed threshold is re-registered every cycle
  always_ff @(posedge Clk) begin
    thr_q <= fixed_thresh;
  end

  assign thr        = thr_q;
  assign warm       = 1'b1;
  assign unused_cfg = (WIN_LOG2 != 0) ^ (K_SHIFT != 0);
`endif

  // Detection FSM next-state and peak tracking
  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    ptime_d = ptime_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARMED: begin
        if (accept && warm && (energy > thr)) begin
          state_d = ABOVE;
          peak_d  = energy;
          ptime_d = ts_q;
        end
      end
      ABOVE: begin
        if (accept) begin
          if (energy <= thr) begin
            state_d = EMIT;
          end else if (energy > peak_q) begin
            peak_d  = energy;
            ptime_d = ts_q;
          end
        end
      end
      EMIT: begin
        if (spike_ready) begin
          if (REFRACT == 0) begin
            state_d = ARMED;
          end else begin
            state_d = neo_pkg::REFRACT;
            cnt_d   = CW'(REFRACT);
          end
        end
      end
      neo_pkg::REFRACT: begin
        if (accept) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = ARMED;
          end
        end
      end
      default: state_d = ARMED;
    endcase
  end

  // State, event registers and sample index
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= ARMED;
      peak_q  <= '0;
      ptime_q <= '0;
      cnt_q   <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      ptime_q <= ptime_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        ts_q <= ts_q + 1'b1;
      end
    end
  end

  assign spike_valid = (state_q == EMIT);
  assign spike_time  = ptime_q;
  assign spike_peak  = peak_q;

endmodule

// File: tb/tb_neo_spike_detector.sv
// Scoreboard bench for neo_spike_detector (TW = 4, REFRACT = 2).
// Fixed-threshold scenarios in the default build; adaptive scenarios when
// NEO_DET_ADAPTIVE_EN is defined.
module tb_neo_spike_detector;

  localparam int unsigned M  = 16;
  localparam int unsigned TW = 4;

  logic          Clk = 1'b0;
  logic          reset;
  logic          energy_valid;
  logic [M-1:0]  energy;
  logic          energy_ready;
  logic [M-1:0]  fixed_thresh;
  logic          spike_valid;
  logic          spike_ready;
  logic [TW-1:0] spike_time;
  logic [M-1:0]  spike_peak;

  typedef struct packed {
    logic [TW-1:0] t;
    logic [M-1:0]  p;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;

  always #5 Clk = ~Clk;

  neo_spike_detector #(
    .M        (M),
    .TW       (TW),
    .REFRACT  (2),
    .WIN_LOG2 (4),
    .K_SHIFT  (3)
  ) dut (
    .Clk          (Clk),
    .reset        (reset),
    .energy_valid (energy_valid),
    .energy       (energy),
    .energy_ready (energy_ready),
    .fixed_thresh (fixed_thresh),
    .spike_valid  (spike_valid),
    .spike_ready  (spike_ready),
    .spike_time   (spike_time),
    .spike_peak   (spike_peak)
  );

  // Scoreboard: every event handshake is compared against the queue head
  always @(negedge Clk) begin
    if (!reset && spike_valid && spike_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_spike time=%0d peak=%0d (no event expected)", spike_time, spike_peak);
      end else begin
        mon_e = exp_q.pop_front();
        if (spike_time !== mon_e.t || spike_peak !== mon_e.p) begin
          errors++;
          $display("FAIL spike_event got time=%0d peak=%0d expected time=%0d peak=%0d",
                   spike_time, spike_peak, mon_e.t, mon_e.p);
        end
      end
    end
  end

  task automatic do_reset(input int unsigned n);
    @(posedge Clk); #1;
    reset = 1'b1;
    repeat (n) @(posedge Clk);
    #1 reset = 1'b0;
  endtask

  // Drives one sample and waits (bounded) until it is accepted
  task automatic send(input logic [M-1:0] v);
    int unsigned n;
    n = 0;
    energy       = v;
    energy_valid = 1'b1;
    forever begin
      @(negedge Clk);
      if (energy_ready === 1'b1) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout value=%0d energy_ready=%b required 1", v, energy_ready);
        energy_valid = 1'b0;
        return;
      end
    end
    @(posedge Clk); #1;
    energy_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk); #1;
      if (exp_q.size() == 0 && spike_valid !== 1'b1) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (energy_ready !== 1'b0) begin errors++; $display("FAIL reset_energy_ready got %b required 0", energy_ready); end
    checks++;
    if (spike_valid !== 1'b0) begin errors++; $display("FAIL reset_spike_valid got %b required 0", spike_valid); end
    checks++;
    if (spike_time !== '0) begin errors++; $display("FAIL reset_spike_time got %0d required 0", spike_time); end
    checks++;
    if (spike_peak !== '0) begin errors++; $display("FAIL reset_spike_peak got %0d required 0", spike_peak); end
    reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (energy_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b required 1", energy_ready); end
    @(posedge Clk); #1;
  endtask

`ifndef NEO_DET_ADAPTIVE_EN
  task automatic test_stream();
    logic [M-1:0] s [9] = '{16'd10, 16'd150, 16'd300, 16'd200, 16'd50, 16'd120, 16'd10, 16'd400, 16'd5};
    do_reset(2);
    exp_q.push_back('{t: 4'd2, p: 16'd300});
    exp_q.push_back('{t: 4'd7, p: 16'd400});
    foreach (s[i]) send(s[i]);
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stream_pending got %0d events left required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset(2);
    spike_ready = 1'b0;
    exp_q.push_back('{t: 4'd1, p: 16'd200});
    send(16'd10);
    send(16'd200);
    send(16'd10);
    checks++;
    if (spike_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise got %b required 1", spike_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++;
      if (spike_valid !== 1'b1 || energy_ready !== 1'b0 || spike_time !== 4'd1 || spike_peak !== 16'd200) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b time=%0d peak=%0d required 1 0 1 200",
                 i, spike_valid, energy_ready, spike_time, spike_peak);
      end
    end
    @(posedge Clk); #1;
    spike_ready = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (energy_ready !== 1'b1 || spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got ready=%b valid=%b required 1 0", energy_ready, spike_valid);
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_pending got %0d events left required 0", exp_q.size()); end
  endtask

  task automatic test_tie();
    logic [M-1:0] s [4] = '{16'd100, 16'd500, 16'd500, 16'd90};
    do_reset(2);
    exp_q.push_back('{t: 4'd1, p: 16'd500});
    foreach (s[i]) send(s[i]);
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL tie_pending got %0d events left required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [M-1:0] s [8] = '{16'd200, 16'd500, 16'd300, 16'd10, 16'd10, 16'd10, 16'd700, 16'd10};
    do_reset(2);
    exp_q.push_back('{t: 4'd15, p: 16'd500});
    exp_q.push_back('{t: 4'd4,  p: 16'd700});
    repeat (14) send(16'd10);
    foreach (s[i]) send(s[i]);
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending got %0d events left required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic saw;
    do_reset(2);
    send(16'd10);
    send(16'd200);
    reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (spike_valid !== 1'b0 || energy_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got valid=%b ready=%b required 0 0", spike_valid, energy_ready);
    end
    reset = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      if (spike_valid === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL mid_reset_ghost got spike_valid=1 required 0"); end
    @(posedge Clk); #1;
    exp_q.push_back('{t: 4'd1, p: 16'd300});
    send(16'd10);
    send(16'd300);
    send(16'd10);
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_reset_pending got %0d events left required 0", exp_q.size()); end
  endtask
`else
  task automatic test_adaptive();
    do_reset(2);
    repeat (16) send(16'd1000);
    checks++;
    if (spike_valid !== 1'b0 || energy_ready !== 1'b1) begin
      errors++;
      $display("FAIL warmup_state got valid=%b ready=%b required 0 1", spike_valid, energy_ready);
    end
    // Index 16 wraps to 0 with TW = 4
    exp_q.push_back('{t: 4'd0, p: 16'd60000});
    repeat (30) send(16'd60000);
    repeat (4) send(16'hFFFF);
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL adaptive_pending got %0d events left required 0", exp_q.size()); end
    checks++;
    if (spike_valid !== 1'b0) begin errors++; $display("FAIL adaptive_saturation got spike_valid=%b required 0", spike_valid); end
  endtask

  task automatic test_reset_mid();
    logic saw;
    do_reset(2);
    repeat (16) send(16'd1000);
    send(16'd60000);
    reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (spike_valid !== 1'b0 || energy_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got valid=%b ready=%b required 0 0", spike_valid, energy_ready);
    end
    reset = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      if (spike_valid === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL mid_reset_ghost got spike_valid=1 required 0"); end
    @(posedge Clk); #1;
    exp_q.push_back('{t: 4'd0, p: 16'd60000});
    repeat (16) send(16'd1000);
    repeat (3) send(16'd60000);
    send(16'd1000);
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_reset_pending got %0d events left required 0", exp_q.size()); end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    energy_valid = 1'b0;
    energy       = '0;
    fixed_thresh = 16'd100;
    spike_ready  = 1'b1;
    test_reset();
`ifndef NEO_DET_ADAPTIVE_EN
    test_stream();
    test_backpressure();
    test_tie();
    test_wrap();
    test_reset_mid();
`else
    test_adaptive();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/neo_spike_detector.md
# neo_spike_detector

Consumer end of the NEO energy stream. Accepts one unsigned energy value per handshake from the NEO output, compares it against a threshold, and groups each supra-threshold run into one spike event. Each event carries the peak energy and the sample index of that peak, and is followed by a refractory interval. Sits directly downstream of NEO and upstream of the event logger.

## Interface
- M, 16, energy width (matches NEO M)
- TW, 16, sample-index / timestamp width
- REFRACT, 8, refractory length in accepted samples (0 allowed)
- WIN_LOG2, 4, EMA time constant shift; warm-up length 2^WIN_LOG2 samples
- K_SHIFT, 3, threshold = EMA << K_SHIFT
- Clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- energy_valid  input  1  energy word valid
- energy  input  M  unsigned NEO energy
- energy_ready  output  1  detector accepts energy this cycle
- fixed_thresh  input  M  unsigned threshold, used only without the macro
- spike_valid  output  1  spike event valid
- spike_ready  input  1  downstream accepts event
- spike_time  output  TW  sample index of peak
- spike_peak  output  M  peak energy of event

## Operation
- Accept: energy_valid && energy_ready. Index counter ts (TW bits) = index of the current accepted sample; it increments after each accept and wraps 2^TW-1 -> 0.
- Threshold thr is registered. Each sample is compared against thr as it stood before that sample's own update.
- FSM states:
  - ARMED: if sample > thr (strict), go to ABOVE and record peak = sample, ptime = ts.
  - ABOVE: if sample > peak, update peak/ptime (ties keep the earlier sample). If sample <= thr, go to EMIT; the terminating sample is not a peak candidate.
  - EMIT: spike_valid = 1, spike_time = ptime, spike_peak = peak, held stable; energy_ready = 0. On spike_ready, go to REFRACT with cnt = REFRACT, or go to ARMED if REFRACT = 0.
  - REFRACT: each accept decrements cnt; the accept that brings cnt to 0 returns to ARMED. No detection occurs in this state, but the threshold still updates.
- energy_ready = 1 in ARMED, ABOVE and REFRACT; 0 in EMIT and while reset is asserted.
- A run still above threshold when ts wraps remains a single event; ptime carries its wrapped value.

## Timing
- Reset values: spike_valid 0, spike_time 0, spike_peak 0, energy_ready 0 during reset and 1 from the first cycle after. Internal: state ARMED, ts 0, EMA 0, warm-up count 0, cnt 0.
- spike_valid rises the cycle after the terminating sample is accepted.
- Event-to-next-accept latency: 1 cycle after the spike_ready handshake.
- Reset mid-event discards the event. No spike_valid appears after reset deasserts.

## Configuration
- NEO_DET_ADAPTIVE_EN defined: the EMA threshold is active.
  - avg <= avg + ((energy - avg) >>> WIN_LOG2), computed signed in M+1 bits.
  - thr = avg << K_SHIFT, saturated to 2^M-1.
  - Detection is inhibited (state stays ARMED) until 2^WIN_LOG2 samples have been accepted since reset.
  - fixed_thresh is ignored.
- Not defined: thr = fixed_thresh, registered each cycle, with no warm-up. No EMA logic is built.

## Structure
- The shared package neo_pkg holds:
  - typedef enum det_state_t {ARMED, ABOVE, EMIT, REFRACT}
  - default constants for M, TW, REFRACT, WIN_LOG2 and K_SHIFT
- Sub-module neo_ema_threshold contains the EMA, saturation and warm-up counter. It is instantiated only under NEO_DET_ADAPTIVE_EN.

## Test plan
- Fixed mode, fixed_thresh = 100, REFRACT = 2; stream 10, 150, 300, 200, 50, 120, 10, 400, 5:
  - Event with peak 300 at time 2.
  - 120 is dropped by the refractory interval.
  - Event with peak 400 at time 7.
- Backpressure: spike_ready held 0 for 5 cycles during EMIT -> energy_ready = 0 and outputs stable; the event completes on spike_ready.
- Tie handling: run of 100, 500, 500, 90 with thr 100 -> peak 500 at the first 500's index.
- Wrap: TW = 4, event peak at index 15, next sample at 0 -> spike_time = 15, and the next event index counts from 0.
- Adaptive, WIN_LOG2 = 4, K_SHIFT = 3: constant 1000 input produces no event during warm-up. After warm-up, a single sample of 60000 yields a spike, and the threshold saturates with no overflow.
- Reset asserted in ABOVE -> no spike_valid appears, and the index restarts at 0.
